// File: rtl/rca_pkg.sv
// Shared types and constants for the ripple-carry adder launch/capture stage.
package rca_pkg;

    localparam int RCA_WIDTH        = 14;
    localparam int RCA_RES_WIDTH    = 15;
    localparam int SETTLE_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } rca_state_e;

endpackage

// File: rtl/rca_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear wins over enable; the count sticks at all-ones instead of wrapping.
module rca_sat_counter
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Count register: clear first, then increment unless already saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rca_launch_capture.sv
// Launch/capture wrapper around the combinational ripple-carry adder netlist.
// Operands are registered onto the adder inputs, the carry chain is given a
// programmable settle time, and the sampled result is checked against a
// behavioural sum before being handed downstream.
module rca_launch_capture
    import rca_pkg::*;
#(
    parameter int WIDTH         = RCA_WIDTH,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_term1,
    input  logic [WIDTH-1:0]     i_term2,
    output logic [WIDTH-1:0]     o_add_term1,
    output logic [WIDTH-1:0]     o_add_term2,
    input  logic [WIDTH:0]       i_add_result,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH:0]       o_result,
    output logic                 o_mismatch,
    output logic [CNT_WIDTH-1:0] o_txn_count,
    output logic [CNT_WIDTH-1:0] o_err_count,
    input  logic                 i_clear
);

    localparam logic [SETTLE_CNT_WIDTH-1:0] SETTLE_LOAD = SETTLE_CNT_WIDTH'(SETTLE_CYCLES - 1);

    rca_state_e                  state;
    rca_state_e                  next_state;
    logic [SETTLE_CNT_WIDTH-1:0] settle_cnt;
    logic [WIDTH:0]              expected_sum;
    logic                        accept;
    logic                        retire;

    assign accept = (state == IDLE) && i_valid;
    assign retire = (state == HOLD) && i_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one transaction in flight, no overlap
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_valid)            next_state = SETTLE;
            SETTLE:  if (settle_cnt == '0)   next_state = HOLD;
            HOLD:    if (i_ready)            next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the state
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state)
            IDLE:    o_ready = 1'b1;
            HOLD:    o_valid = 1'b1;
            default: ;
        endcase
    end

    // Launch operands and reference sum on accept, sample the adder when settled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_add_term1  <= '0;
            o_add_term2  <= '0;
            expected_sum <= '0;
            settle_cnt   <= '0;
            o_result     <= '0;
            o_mismatch   <= 1'b0;
        end else if (accept) begin
            o_add_term1  <= i_term1;
            o_add_term2  <= i_term2;
            expected_sum <= {1'b0, i_term1} + {1'b0, i_term2};
            settle_cnt   <= SETTLE_LOAD;
        end else if (state == SETTLE) begin
            if (settle_cnt == '0) begin
                o_result   <= i_add_result;
                o_mismatch <= (i_add_result != expected_sum);
            end else begin
                settle_cnt <= settle_cnt - 1'b1;
            end
        end
    end

    rca_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_txn_counter (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (i_clear),
        .enable (retire),
        .count  (o_txn_count)
    );

    rca_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_counter (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (i_clear),
        .enable (retire && o_mismatch),
        .count  (o_err_count)
    );

endmodule

// File: tb/tb_rca_launch_capture.sv
// Testbench for rca_launch_capture with a behavioural adder (optionally with
// its carry-out stuck at 0) and a scoreboard of expected results.
// Counters are built 4 bits wide here so saturation is reachable quickly.
module tb_rca_launch_capture;

    localparam int WIDTH  = 14;
    localparam int RES_W  = WIDTH + 1;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             mismatch;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             up_valid = 1'b0;
    logic             up_ready;
    logic [WIDTH-1:0] term1 = '0;
    logic [WIDTH-1:0] term2 = '0;
    logic [WIDTH-1:0] add_term1;
    logic [WIDTH-1:0] add_term2;
    logic [RES_W-1:0] add_result;
    logic             dn_valid;
    logic             dn_ready = 1'b0;
    logic [RES_W-1:0] result;
    logic             mismatch;
    logic [CNT_W-1:0] txn_count;
    logic [CNT_W-1:0] err_count;
    logic             clear = 1'b0;

    logic             carry_stuck = 1'b0;
    logic [RES_W-1:0] true_sum;

    int               vectors = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] txn_model = '0;
    logic [CNT_W-1:0] err_model = '0;
    exp_t             sb[$];

    always #5 clk = ~clk;

    // Behavioural adder netlist stand-in, with optional carry-out fault
    assign true_sum   = {1'b0, add_term1} + {1'b0, add_term2};
    assign add_result = carry_stuck ? {1'b0, true_sum[WIDTH-1:0]} : true_sum;

    rca_launch_capture #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE),
        .CNT_WIDTH     (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (up_valid),
        .o_ready      (up_ready),
        .i_term1      (term1),
        .i_term2      (term2),
        .o_add_term1  (add_term1),
        .o_add_term2  (add_term2),
        .i_add_result (add_result),
        .o_valid      (dn_valid),
        .i_ready      (dn_ready),
        .o_result     (result),
        .o_mismatch   (mismatch),
        .o_txn_count  (txn_count),
        .o_err_count  (err_count),
        .i_clear      (clear)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic reportTimeout(input string tag);
        vectors++;
        miscompares++;
        $error("[TB] FAIL %s: observed timeout, expected handshake", tag);
    endtask

    // Offer one operand pair (at a negedge) and push its expected outcome
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [RES_W-1:0] s;
        logic [RES_W-1:0] r;
        exp_t             e;
        int               waited;
        waited = 0;
        while (!up_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!up_ready) reportTimeout("ready_wait");
        term1    = a;
        term2    = b;
        up_valid = 1'b1;
        s = {1'b0, a} + {1'b0, b};
        r = carry_stuck ? {1'b0, s[WIDTH-1:0]} : s;
        e.result   = r;
        e.mismatch = (r != s);
        sb.push_back(e);
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    // Wait for a result, optionally stall it, then accept and check counters
    task automatic collectResult(input int hold, input bit poke, input bit clr);
        exp_t e;
        int   waited;
        waited = 0;
        while (!dn_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!dn_valid) begin
            reportTimeout("valid_wait");
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            reportTimeout("scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            checkOutput("hold_valid", dn_valid, 1);
            checkOutput("hold_ready", up_ready, 0);
            checkOutput("hold_result", result, e.result);
            checkOutput("hold_mismatch", mismatch, e.mismatch);
            if (poke && i == 1) begin
                term1    = 14'h0001;
                term2    = 14'h0001;
                up_valid = 1'b1;
            end else begin
                up_valid = 1'b0;
            end
            @(negedge clk);
        end
        up_valid = 1'b0;
        checkOutput("result", result, e.result);
        checkOutput("mismatch", mismatch, e.mismatch);
        dn_ready = 1'b1;
        clear    = clr;
        if (clr) begin
            txn_model = '0;
            err_model = '0;
        end else begin
            if (txn_model != CNT_MAX) txn_model = txn_model + 1'b1;
            if (e.mismatch && err_model != CNT_MAX) err_model = err_model + 1'b1;
        end
        @(negedge clk);
        dn_ready = 1'b0;
        clear    = 1'b0;
        checkOutput("valid_drop", dn_valid, 0);
        checkOutput("ready_back", up_ready, 1);
        checkOutput("txn_count", txn_count, txn_model);
        checkOutput("err_count", err_count, err_model);
    endtask

    // Bounded run time so a stuck design still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", up_ready, 1);
        checkOutput("rst_valid", dn_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_mismatch", mismatch, 0);
        checkOutput("rst_add_term1", add_term1, 0);
        checkOutput("rst_add_term2", add_term2, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_ready", up_ready, 1);
            checkOutput("idle_valid", dn_valid, 0);
            checkOutput("idle_txn", txn_count, 0);
            checkOutput("idle_err", err_count, 0);
        end

        // Basic transaction and latency: valid on the 3rd edge counting the accept edge
        applyStimulus(14'h1234, 14'h0ABC);
        checkOutput("launch_term1", add_term1, 14'h1234);
        checkOutput("launch_term2", add_term2, 14'h0ABC);
        checkOutput("lat_edge1_valid", dn_valid, 0);
        checkOutput("lat_edge1_ready", up_ready, 0);
        @(negedge clk);
        checkOutput("lat_edge2_valid", dn_valid, 0);
        @(negedge clk);
        checkOutput("lat_edge3_valid", dn_valid, 1);
        checkOutput("lat_result", result, 15'h1CF0);
        collectResult(0, 1'b0, 1'b0);
        checkOutput("first_txn", txn_count, 1);

        // All-ones operands, downstream stall, ignored i_valid during HOLD
        applyStimulus(14'h3FFF, 14'h3FFF);
        collectResult(5, 1'b1, 1'b0);
        checkOutput("max_result_kept", result, 15'h7FFE);
        checkOutput("hold_term1_kept", add_term1, 14'h3FFF);
        checkOutput("hold_term2_kept", add_term2, 14'h3FFF);

        // Carry-out stuck at 0
        carry_stuck = 1'b1;
        applyStimulus(14'h2000, 14'h2000);
        collectResult(0, 1'b0, 1'b0);
        checkOutput("fault_result", result, 15'h0000);
        checkOutput("fault_err", err_count, 1);

        // Drive both counters into saturation with carrying operands
        for (int i = 0; i < 16; i++) begin
            ra = 14'(14'h2000 + $urandom_range(0, 14'h1FFF));
            rb = 14'(14'h2000 + $urandom_range(0, 14'h1FFF));
            applyStimulus(ra, rb);
            collectResult(0, 1'b0, 1'b0);
        end
        checkOutput("sat_txn", txn_count, CNT_MAX);
        checkOutput("sat_err", err_count, CNT_MAX);
        carry_stuck = 1'b0;

        // Clear coincident with an accept wins
        applyStimulus(14'h0005, 14'h0006);
        collectResult(0, 1'b0, 1'b1);
        checkOutput("clear_txn", txn_count, 0);
        checkOutput("clear_err", err_count, 0);

        // Clear during SETTLE leaves the transaction intact
        applyStimulus(14'h0100, 14'h0200);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        collectResult(0, 1'b0, 1'b0);
        checkOutput("clear_settle_txn", txn_count, 1);

        // Async reset mid-SETTLE discards the transaction
        applyStimulus(14'h1111, 14'h2222);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_valid", dn_valid, 0);
        checkOutput("areset_ready", up_ready, 1);
        checkOutput("areset_txn", txn_count, 0);
        sb.delete();
        txn_model = '0;
        err_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("post_rst_valid", dn_valid, 0);
            checkOutput("post_rst_ready", up_ready, 1);
            checkOutput("post_rst_txn", txn_count, 0);
            checkOutput("post_rst_err", err_count, 0);
        end

        // Recovery transaction
        applyStimulus(14'h0FFF, 14'h0001);
        collectResult(0, 1'b0, 1'b0);
        checkOutput("recover_result", result, 15'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
